// File: rtl/tdm_mux_8_1.sv
// Time-division 8:1 serializer: latches an 8-bit word and emits it LSB-first on y with slot select s.
// Latency: slot 0 appears the cycle after the accepting edge; a frame lasts 8 (9 with parity) * SLOT_CYCLES cycles.
// Backpressure: in_ready_o is high in IDLE or on the last frame cycle only; a held in_valid_i is never dropped or duplicated.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   in_valid_i/_ready_o : word handshake; d_i sampled when both are high
//   y_o, s_o, y_valid_o : serial bit, its slot index, slot-valid flag
//   frame_start_o       : high for every cycle of slot 0
//   frame_end_o         : high on the final cycle of the frame
//   p_slot_o            : high during the parity slot
// Optional feature: define TDM_PARITY_EN to append a ninth even-parity slot (s=7, p_slot=1).
module tdm_mux_8_1 #(
   parameter int unsigned SLOT_CYCLES = 1   // cycles per slot, 1..256
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [7:0] d_i,
   output logic       y_o,
   output logic [2:0] s_o,
   output logic       y_valid_o,
   output logic       frame_start_o,
   output logic       frame_end_o,
   output logic       p_slot_o
);

   localparam int unsigned   PCW    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [PCW-1:0] PC_MAX = PCW'(SLOT_CYCLES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state_q, state_d;
   logic [7:0]     w_q, w_d;
   logic [2:0]     slot_q, slot_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic           slot_end;
   logic           last;
   logic           accept;

   assign slot_end = (state_q == SEND) && (pc_q == PC_MAX);

`ifdef TDM_PARITY_EN
   // The slot counter stays at 7 through the parity slot; par_q marks it.
   logic par_q, par_d;
   assign last = slot_end && par_q;
`else
   assign last = slot_end && (slot_q == 3'd7);
`endif

   assign in_ready_o = (state_q == IDLE) || last;
   assign accept     = in_valid_i && in_ready_o;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      slot_d  = slot_q;
      pc_d    = pc_q;
`ifdef TDM_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         state_d = SEND;
         w_d     = d_i;
         slot_d  = 3'd0;
         pc_d    = '0;
`ifdef TDM_PARITY_EN
         par_d   = 1'b0;
`endif
      end else if (state_q == SEND) begin
         if (last) begin
            state_d = IDLE;
            slot_d  = 3'd0;
            pc_d    = '0;
`ifdef TDM_PARITY_EN
            par_d   = 1'b0;
`endif
         end else if (slot_end) begin
            pc_d = '0;
`ifdef TDM_PARITY_EN
            if (slot_q == 3'd7) par_d  = 1'b1;
            else                slot_d = slot_q + 3'd1;
`else
            slot_d = slot_q + 3'd1;
`endif
         end else begin
            pc_d = pc_q + PCW'(1);
         end
      end
   end

   // Output decode
   always_comb begin
      y_o           = 1'b0;
      s_o           = 3'd0;
      y_valid_o     = 1'b0;
      frame_start_o = 1'b0;
      p_slot_o      = 1'b0;
      frame_end_o   = last;
      if (state_q == SEND) begin
         y_valid_o     = 1'b1;
         s_o           = slot_q;
         y_o           = w_q[slot_q];
         frame_start_o = (slot_q == 3'd0);
`ifdef TDM_PARITY_EN
         if (par_q) begin
            y_o           = ^w_q;
            p_slot_o      = 1'b1;
            frame_start_o = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         w_q     <= 8'd0;
         slot_q  <= 3'd0;
         pc_q    <= '0;
`ifdef TDM_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         slot_q  <= slot_d;
         pc_q    <= pc_d;
`ifdef TDM_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Bench for tdm_mux_8_1: two instances (SLOT_CYCLES=1 and 3) compared every cycle
// against a frame-position model, plus directed frames with literal expectations.
module tb_tdm_mux_8_1;

`ifdef TDM_PARITY_EN
   localparam int NSLOT = 9;
`else
   localparam int NSLOT = 8;
`endif
   localparam int SC0 = 1;
   localparam int SC1 = 3;

   logic       clk;
   logic       rst;
   logic       vld   [2];
   logic [7:0] d     [2];
   logic       rdy_w [2];
   logic       y_w   [2];
   logic [2:0] s_w   [2];
   logic       yv_w  [2];
   logic       fs_w  [2];
   logic       fe_w  [2];
   logic       ps_w  [2];

   int vectors = 0;
   int miscompares = 0;

   tdm_mux_8_1 #(.SLOT_CYCLES(SC0)) dut0 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(vld[0]), .in_ready_o(rdy_w[0]), .d_i(d[0]),
      .y_o(y_w[0]), .s_o(s_w[0]), .y_valid_o(yv_w[0]), .frame_start_o(fs_w[0]),
      .frame_end_o(fe_w[0]), .p_slot_o(ps_w[0]));

   tdm_mux_8_1 #(.SLOT_CYCLES(SC1)) dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(vld[1]), .in_ready_o(rdy_w[1]), .d_i(d[1]),
      .y_o(y_w[1]), .s_o(s_w[1]), .y_valid_o(yv_w[1]), .frame_start_o(fs_w[1]),
      .frame_end_o(fe_w[1]), .p_slot_o(ps_w[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sc_of(input int i);
      return (i == 0) ? SC0 : SC1;
   endfunction

   // Model: remaining cycles of the current frame (0 = idle) and the latched word.
   int         rem [2] = '{0, 0};
   logic [7:0] wm  [2] = '{8'd0, 8'd0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rem[i] = 0;
            wm[i]  = 8'd0;
         end else if (vld[i] && (rem[i] <= 1)) begin
            wm[i]  = d[i];
            rem[i] = NSLOT * sc_of(i);
         end else if (rem[i] > 0) begin
            rem[i] = rem[i] - 1;
         end
      end
   end

   // Captured serial stream per instance, with first/last valid cycle numbers.
   bit cap0[$];
   bit cap1[$];
   int cyc = 0;
   int first_v [2] = '{-1, -1};
   int last_v  [2] = '{-1, -1};

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         int   idx, sl;
         logic ev, ey, efs, efe, eps;
         logic [2:0] es;
         ev  = (rem[i] > 0);
         idx = NSLOT * sc_of(i) - rem[i];
         sl  = idx / sc_of(i);
         ey  = 1'b0; es = 3'd0; efs = 1'b0; eps = 1'b0;
         if (ev) begin
            ey  = (sl < 8) ? wm[i][sl] : ^wm[i];
            es  = (sl < 8) ? 3'(sl) : 3'd7;
            efs = (sl == 0);
            eps = (sl == 8);
         end
         efe = (rem[i] == 1);
         chk($sformatf("dut%0d.in_ready", i),    32'(rdy_w[i]), 32'(rem[i] <= 1));
         chk($sformatf("dut%0d.y_valid", i),     32'(yv_w[i]),  32'(ev));
         chk($sformatf("dut%0d.y", i),           32'(y_w[i]),   32'(ey));
         chk($sformatf("dut%0d.s", i),           32'(s_w[i]),   32'(es));
         chk($sformatf("dut%0d.frame_start", i), 32'(fs_w[i]),  32'(efs));
         chk($sformatf("dut%0d.frame_end", i),   32'(fe_w[i]),  32'(efe));
         chk($sformatf("dut%0d.p_slot", i),      32'(ps_w[i]),  32'(eps));
         if (yv_w[i] === 1'b1) begin
            if (first_v[i] < 0) first_v[i] = cyc;
            last_v[i] = cyc;
         end
      end
      if (yv_w[0] === 1'b1) cap0.push_back(y_w[0]);
      if (yv_w[1] === 1'b1) cap1.push_back(y_w[1]);
   end

   bit exp_q[$];

   task automatic push_word(input logic [7:0] w, input int rep);
      for (int s = 0; s < NSLOT; s++) begin
         bit b;
         b = (s < 8) ? w[s] : ^w;
         for (int r = 0; r < rep; r++) exp_q.push_back(b);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_caps();
      cap0.delete();
      cap1.delete();
      exp_q.delete();
      first_v = '{-1, -1};
      last_v  = '{-1, -1};
   endtask

   task automatic cmp_stream(input string nm, input int i);
      int n;
      n = (i == 0) ? cap0.size() : cap1.size();
      chk({nm, ".len"}, 32'(n), 32'(exp_q.size()));
      for (int k = 0; k < n && k < exp_q.size(); k++)
         chk($sformatf("%s.bit%0d", nm, k), 32'((i == 0) ? cap0[k] : cap1[k]), 32'(exp_q[k]));
      if (n > 0) chk({nm, ".nogap"}, 32'(last_v[i] - first_v[i] + 1), 32'(n));
   endtask

   // Sends one word on instance i and lets the frame drain.
   task automatic send_one(input int i, input logic [7:0] w);
      vld[i] = 1'b1;
      d[i]   = w;
      tick(1);
      vld[i] = 1'b0;
      d[i]   = $urandom_range(0, 255);   // must be ignored after acceptance
      tick(NSLOT * sc_of(i) + 2);
   endtask

   initial begin
      logic [7:0] packed_bits;
      rst = 1'b1;
      vld = '{1'b1, 1'b1};
      d   = '{8'hFF, 8'hFF};
      clear_caps();

      // Reset held with valid asserted: nothing accepted
      tick(2);
      chk("reset.in_ready", 32'(rdy_w[0]), 32'd1);
      chk("reset.y_valid",  32'(yv_w[0]),  32'd0);
      chk("reset.y",        32'(y_w[0]),   32'd0);
      chk("reset.s",        32'(s_w[1]),   32'd0);
      rst = 1'b0;
      vld = '{1'b0, 1'b0};
      tick(1);
      chk("reset.no_frame", 32'(cap0.size() + cap1.size()), 32'd0);

      // Single frame, SLOT_CYCLES=1
      clear_caps();
      send_one(0, 8'b1010_0110);
      packed_bits = 8'd0;
      for (int k = 0; k < 8 && k < cap0.size(); k++) packed_bits[k] = cap0[k];
      chk("single.bits", 32'(packed_bits), 32'h0A6);
      push_word(8'hA6, 1);
      cmp_stream("single", 0);

      // Back-to-back with valid held
      clear_caps();
      vld[0] = 1'b1;
      d[0]   = 8'hA5;
      tick(1);
      d[0]   = 8'h3C;
      tick(NSLOT);
      vld[0] = 1'b0;
      tick(NSLOT + 2);
      chk("b2b.count", 32'(cap0.size()), 32'(2 * NSLOT));
      push_word(8'hA5, 1);
      push_word(8'h3C, 1);
      cmp_stream("b2b", 0);

      // Prescale, SLOT_CYCLES=3
      clear_caps();
      send_one(1, 8'h81);
      chk("prescale.len", 32'(cap1.size()), 32'(NSLOT * 3));
      push_word(8'h81, 3);
      cmp_stream("prescale", 1);

      // Abort during slot 4 of 8'hFF
      clear_caps();
      vld[0] = 1'b1;
      d[0]   = 8'hFF;
      tick(1);
      vld[0] = 1'b0;
      tick(4);
      chk("abort.in_slot4", 32'(s_w[0]), 32'd4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("abort.y_valid",  32'(yv_w[0]),  32'd0);
      chk("abort.s",        32'(s_w[0]),   32'd0);
      chk("abort.in_ready", 32'(rdy_w[0]), 32'd1);
      tick(2);
      clear_caps();
      send_one(0, 8'h01);
      push_word(8'h01, 1);
      cmp_stream("after_abort", 0);

`ifdef TDM_PARITY_EN
      clear_caps();
      send_one(0, 8'b0000_0111);
      chk("parity07.len", 32'(cap0.size()), 32'd9);
      if (cap0.size() == 9) chk("parity07.bit", 32'(cap0[8]), 32'd1);
      clear_caps();
      send_one(0, 8'h03);
      chk("parity03.len", 32'(cap0.size()), 32'd9);
      if (cap0.size() == 9) chk("parity03.bit", 32'(cap0[8]), 32'd0);
`endif

      // Random traffic on both instances; per-cycle model compare does the checking
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < 2; i++) begin
            vld[i] = ($urandom_range(0, 3) != 0);
            d[i]   = 8'($urandom_range(0, 255));
         end
         tick(1);
      end
      rst = 1'b0;
      vld = '{1'b0, 1'b0};
      tick(NSLOT * SC1 + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
